// File: rtl/memfetch_pkg.sv
// Shared types and constants for the memory word fetcher.
package memfetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    // Operand size codes on the size input; 2'b11 is illegal
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Data register load modes
    localparam logic [1:0] FS_SEXT = 2'b00;
    localparam logic [1:0] FS_ZEXT = 2'b01;
    localparam logic [1:0] FS_SHL  = 2'b10;
    localparam logic [1:0] FS_SHR  = 2'b11;

    // Index of the last byte of an operand (N-1) for a legal size code
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_word_fetcher_if.sv
// Request, memory-port and data-register signals of the word fetcher.
interface mem_word_fetcher_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  sign_ext;
    logic                  little_endian;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic [7:0]            mem_rdata;
    logic                  dr_enable;
    logic [1:0]            dr_funsel;
    logic [7:0]            dr_i;
    logic                  busy;
    logic                  done;
    logic                  err;

    // Fetcher side
    modport master (
        input  start, addr, size, sign_ext, little_endian, mem_rdata,
        output mem_addr, mem_re, dr_enable, dr_funsel, dr_i, busy, done, err
    );

    // Controller / memory / DR side
    modport slave (
        output start, addr, size, sign_ext, little_endian, mem_rdata,
        input  mem_addr, mem_re, dr_enable, dr_funsel, dr_i, busy, done, err
    );
endinterface

// File: rtl/mem_word_fetcher.sv
// Reads a 1, 2 or 4 byte operand from byte-wide synchronous memory and
// steers each byte into the data register with the matching load mode.
module mem_word_fetcher
    import memfetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input logic                clock,
    input logic                reset,
    mem_word_fetcher_if.master bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            last_q, last_d;
    logic                  sext_q, sext_d;
    logic                  le_q, le_d;
    logic                  err_q, err_d;
    logic                  dr_en_q, dr_en_d;
    logic [1:0]            fs_q, fs_d;
    logic                  accept;
    logic                  legal;

    // Request acceptance: only while not busy (idle or the done cycle)
    always_comb begin
        accept = bus.start && ((state_q == StIdle) || (state_q == StDone));
        legal  = (bus.size != 2'b11);
    end

    // Next-state, address walk, byte count and DR control one cycle behind the read
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sext_d  = sext_q;
        le_d    = le_q;
        err_d   = err_q;
        dr_en_d = 1'b0;
        fs_d    = FS_SEXT;

        // Read data lands the cycle after mem_re, so DR control trails the read state
        if (state_q == StRead) begin
            dr_en_d = 1'b1;
            if (cnt_q == 2'd0) begin
                fs_d = sext_q ? FS_SEXT : FS_ZEXT;
            end else begin
                fs_d = FS_SHL;
            end
        end

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
                if (accept) begin
                    if (legal) begin
                        state_d = StRead;
                        last_d  = size_last(bus.size);
                        cnt_d   = 2'd0;
                        sext_d  = bus.sign_ext;
                        le_d    = bus.little_endian;
                        // Little-endian walks down from the most significant byte
                        addr_d  = bus.little_endian
                                ? bus.addr + ADDR_WIDTH'(size_last(bus.size))
                                : bus.addr;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StRead: begin
                cnt_d  = cnt_q + 2'd1;
                addr_d = le_q ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                if (cnt_q == last_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and captured request registers; reset aborts any transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            sext_q  <= 1'b0;
            le_q    <= 1'b0;
            err_q   <= 1'b0;
            dr_en_q <= 1'b0;
            fs_q    <= FS_SEXT;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sext_q  <= sext_d;
            le_q    <= le_d;
            err_q   <= err_d;
            dr_en_q <= dr_en_d;
            fs_q    <= fs_d;
        end
    end

    // Outputs decode directly from registers so reset clears them at once
    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_re    = (state_q == StRead);
        bus.busy      = (state_q == StRead) || (state_q == StDrain);
        bus.done      = (state_q == StDone);
        bus.err       = err_q;
        bus.dr_enable = dr_en_q;
        bus.dr_funsel = fs_q;
        bus.dr_i      = bus.mem_rdata;
    end

endmodule
